// File: rtl/vram_pkg.sv
// Shared 640x480@60 raster timing, pixel geometry and scan FSM state type.
// The VRAM write side reuses PIX_COUNT so both ports agree on the frame size.
package vram_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;

    localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int PIX_COUNT = H_ACTIVE * V_ACTIVE;

    localparam int ADDRW = 20;
    localparam int DATAW = 24;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } scan_state_t;

endpackage

// File: rtl/vga_phase_counter.sv
// One raster axis counter: ACTIVE, FP, SYNC, BP phases in that order.
// wrap_o is combinational so the next axis can step on the same clock edge.
module vga_phase_counter #(
    parameter int ACTIVE = 640,
    parameter int FP     = 16,
    parameter int SYNC   = 96,
    parameter int BP     = 48,
    parameter int CNT_W  = $clog2(ACTIVE + FP + SYNC + BP)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] count_o,
    output logic             active_o,
    output logic             sync_o,
    output logic             wrap_o
);

    localparam int TOTAL = ACTIVE + FP + SYNC + BP;
    localparam logic [CNT_W-1:0] LAST       = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] ACT_END    = CNT_W'(ACTIVE);
    localparam logic [CNT_W-1:0] SYNC_START = CNT_W'(ACTIVE + FP);
    localparam logic [CNT_W-1:0] SYNC_LAST  = CNT_W'(ACTIVE + FP + SYNC - 1);

    logic [CNT_W-1:0] count_q, count_d;

    assign wrap_o = inc_i && (count_q == LAST);

    always_comb begin
        count_d = count_q;
        if (clr_i || wrap_o) begin
            count_d = '0;
        end else if (inc_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o  = count_q;
    assign active_o = (count_q < ACT_END);
    assign sync_o   = (count_q >= SYNC_START) && (count_q <= SYNC_LAST);

endmodule

// File: rtl/vram_scan_ctrl.sv
// VRAM scan-out controller: counter stage drives the VRAM read port, one output
// register stage lines sync/DE up with the registered VRAM read data.
module vram_scan_ctrl #(
    parameter int H_ACTIVE = vram_pkg::H_ACTIVE,
    parameter int H_FP     = vram_pkg::H_FP,
    parameter int H_SYNC   = vram_pkg::H_SYNC,
    parameter int H_BP     = vram_pkg::H_BP,
    parameter int V_ACTIVE = vram_pkg::V_ACTIVE,
    parameter int V_FP     = vram_pkg::V_FP,
    parameter int V_SYNC   = vram_pkg::V_SYNC,
    parameter int V_BP     = vram_pkg::V_BP,
    parameter int ADDRW    = vram_pkg::ADDRW,
    parameter int DATAW    = vram_pkg::DATAW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             En,
    output logic             RdEn,
    output logic [ADDRW-1:0] RdAddr,
    input  logic [DATAW-1:0] RdData,
    output logic             HSync,
    output logic             VSync,
    output logic             DE,
    output logic [DATAW-1:0] Pixel,
    output logic             FrameStart,
    output logic             Busy
);

    import vram_pkg::*;

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HCW   = $clog2(H_TOT);
    localparam int VCW   = $clog2(V_TOT);
    localparam logic [ADDRW-1:0] ADDR_LAST = ADDRW'(H_ACTIVE * V_ACTIVE - 1);

    scan_state_t      state_q, state_d;
    logic             running;
    logic [HCW-1:0]   hcnt;
    logic [VCW-1:0]   vcnt;
    logic             h_act, h_sync, h_wrap;
    logic             v_act, v_sync, v_wrap;
    logic             frame_end;
    logic             rd_en;
    logic [ADDRW-1:0] addr_q, addr_d;
    logic             hsync_q, vsync_q, de_q, fs_q;
    logic             hsync_d, vsync_d, de_d, fs_d;

    assign running = (state_q == RUN);

    vga_phase_counter #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .CNT_W(HCW)
    ) u_hcnt (
        .clk(clk), .reset(reset), .inc_i(running), .clr_i(!running),
        .count_o(hcnt), .active_o(h_act), .sync_o(h_sync), .wrap_o(h_wrap)
    );

    vga_phase_counter #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .CNT_W(VCW)
    ) u_vcnt (
        .clk(clk), .reset(reset), .inc_i(h_wrap), .clr_i(!running),
        .count_o(vcnt), .active_o(v_act), .sync_o(v_sync), .wrap_o(v_wrap)
    );

    // The vertical counter only steps on a line wrap, so its wrap marks frame end.
    assign frame_end = v_wrap;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (En) state_d = RUN;
            RUN:     if (frame_end && !En) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign rd_en = running && h_act && v_act;

    always_comb begin
        addr_d = addr_q;
        if (!running || frame_end) begin
            addr_d = '0;
        end else if (rd_en && (addr_q != ADDR_LAST)) begin
            addr_d = addr_q + 1'b1;
        end
    end

    assign hsync_d = !(running && h_sync);
    assign vsync_d = !(running && v_sync);
    assign de_d    = rd_en;
    assign fs_d    = running && (hcnt == '0) && (vcnt == '0);

    // Output stage: one register matches the VRAM's registered read latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q  <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            de_q    <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            de_q    <= de_d;
            fs_q    <= fs_d;
        end
    end

    assign RdEn       = rd_en;
    assign RdAddr     = addr_q;
    assign HSync      = hsync_q;
    assign VSync      = vsync_q;
    assign DE         = de_q;
    assign Pixel      = de_q ? RdData : '0;
    assign FrameStart = fs_q;
    assign Busy       = running;

endmodule

// File: tb/tb_vram_scan_ctrl.sv
// Scoreboard bench for vram_scan_ctrl on a shrunken raster so whole frames fit.
module tb_vram_scan_ctrl;

    localparam int HA = 8, HF = 2, HS = 3, HB = 2;
    localparam int VA = 4, VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int PIX = HA * VA;
    localparam int AW = 6;
    localparam int DW = 24;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          En = 1'b0;
    logic          RdEn;
    logic [AW-1:0] RdAddr;
    logic [DW-1:0] RdData = '0;
    logic          HSync, VSync, DE, FrameStart, Busy;
    logic [DW-1:0] Pixel;

    always #5 clk = ~clk;

    vram_scan_ctrl #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .ADDRW(AW), .DATAW(DW)
    ) dut (
        .clk(clk), .reset(reset), .En(En), .RdEn(RdEn), .RdAddr(RdAddr),
        .RdData(RdData), .HSync(HSync), .VSync(VSync), .DE(DE), .Pixel(Pixel),
        .FrameStart(FrameStart), .Busy(Busy)
    );

    function automatic logic [DW-1:0] memval(input int a);
        return DW'(a * 7 + 66051);
    endfunction

    // VRAM model with registered read
    always @(posedge clk) begin
        if (RdEn) RdData <= memval(int'(RdAddr));
    end

    typedef struct packed {
        logic          de;
        logic          hs;
        logic          vs;
        logic          fs;
        logic [DW-1:0] pix;
    } s1_t;

    s1_t sb[$];
    int  errs = 0;
    int  checks = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    bit  m_run;
    int  m_h, m_v, m_a;
    int  rden_cnt = 0, vs_low = 0, max_addr = 0, last_fs = -1;

    initial begin
        s1_t e;
        bit  exp_rden, endframe;
        m_run = 0; m_h = 0; m_v = 0; m_a = 0;
        e = '{de: 1'b0, hs: 1'b1, vs: 1'b1, fs: 1'b0, pix: '0};
        sb.push_back(e);

        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            exp_rden = m_run && (m_h < HA) && (m_v < VA);
            chk("RdEn", RdEn, exp_rden);
            chk("RdAddr", RdAddr, m_a);
            chk("Busy", Busy, m_run);
            if (sb.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("DE", DE, e.de);
                chk("HSync", HSync, e.hs);
                chk("VSync", VSync, e.vs);
                chk("FrameStart", FrameStart, e.fs);
                chk("Pixel", Pixel, e.pix);
            end

            if (cyc < 300) begin
                if (RdEn) begin
                    rden_cnt++;
                    if (int'(RdAddr) > max_addr) max_addr = int'(RdAddr);
                end
                if (!VSync) vs_low++;
            end
            if (!Busy) last_fs = -1;
            if (FrameStart) begin
                if (last_fs >= 0) chk("fs_period", cyc - last_fs, HT * VT);
                last_fs = cyc;
            end

            reset = (cyc < 2) || (cyc == 350);
            En    = (cyc >= 5 && cyc < 170) || (cyc >= 300);

            if (reset) begin
                e = '{de: 1'b0, hs: 1'b1, vs: 1'b1, fs: 1'b0, pix: '0};
                last_fs = -1;
            end else begin
                e.de  = exp_rden;
                e.hs  = !(m_run && m_h >= HA + HF && m_h < HA + HF + HS);
                e.vs  = !(m_run && m_v >= VA + VF && m_v < VA + VF + VS);
                e.fs  = m_run && m_h == 0 && m_v == 0;
                e.pix = exp_rden ? memval(m_a) : '0;
            end
            sb.push_back(e);

            if (reset) begin
                m_run = 0; m_h = 0; m_v = 0; m_a = 0;
            end else if (!m_run) begin
                m_run = En;
            end else begin
                endframe = (m_h == HT - 1) && (m_v == VT - 1);
                if (endframe) m_a = 0;
                else if (exp_rden && m_a < PIX - 1) m_a++;
                if (m_h == HT - 1) begin
                    m_h = 0;
                    m_v = (m_v == VT - 1) ? 0 : m_v + 1;
                end else begin
                    m_h++;
                end
                if (endframe && !En) m_run = 0;
            end
        end

        chk("rden_two_frames", rden_cnt, 2 * PIX);
        chk("vsync_low_clks", vs_low, 2 * VS * HT);
        chk("last_addr", max_addr, PIX - 1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
